// File: rtl/apb_timer.sv
// apb_timer: APB-style memory-mapped up-counter timer.
// Software writes GOAL, starts and pauses the count through STATUS, and polls CURR.
// Register window (byte addresses): STATUS=base, GOAL=base+1, CURR=base+2.
// Ports:
//   clk     - system clock, all state on rising edge
//   reset   - asynchronous, active-high reset
//   sel     - slave select
//   enable  - access-phase strobe
//   write   - 1=write, 0=read
//   addr    - byte address
//   wdata   - write data
//   rdata   - read data (registered)
//   ready   - transfer complete pulse (registered)
//   slverr  - error response, valid while ready=1 (registered)
module apb_timer #(
    parameter int unsigned timerbits     = 8,
    parameter int unsigned addrWidth     = 32,
    parameter int unsigned timerBaseAddr = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 enable,
    input  logic                 write,
    input  logic [addrWidth-1:0] addr,
    input  logic [timerbits-1:0] wdata,
    output logic [timerbits-1:0] rdata,
    output logic                 ready,
    output logic                 slverr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    localparam logic [addrWidth-1:0] BASE_ADDR = addrWidth'(timerBaseAddr);

    state_e               state_q;
    logic                 start_q;
    logic                 stop_q;
    logic [timerbits-1:0] goal_q;
    logic [timerbits-1:0] curr_q;
    logic [timerbits-1:0] rdata_q;
    logic                 ready_q;
    logic                 slverr_q;

    // Address decode; an address below base wraps to a large offset and misses.
    logic [addrWidth-1:0] offset_c;
    logic                 access_c;
    logic                 hit_status_c;
    logic                 hit_goal_c;
    logic                 hit_curr_c;
    logic                 in_range_c;
    logic                 wr_ctrl_c;
    logic                 count_en_c;
    logic [timerbits-1:0] status_c;

    assign offset_c     = addr - BASE_ADDR;
    assign access_c     = sel & enable & ~ready_q;
    assign hit_status_c = (offset_c == addrWidth'(0));
    assign hit_goal_c   = (offset_c == addrWidth'(1));
    assign hit_curr_c   = (offset_c == addrWidth'(2));
    assign in_range_c   = hit_status_c | hit_goal_c | hit_curr_c;
    assign status_c     = timerbits'({state_q, stop_q, start_q});

    // A bus write to STATUS or GOAL takes priority over the counter on the same edge.
    assign wr_ctrl_c    = access_c & write & (hit_status_c | hit_goal_c);
    assign count_en_c   = (state_q == ST_RUNNING) & ~stop_q & ~wr_ctrl_c;

    // Bus response, control state and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            goal_q   <= '0;
            curr_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            ready_q <= access_c;

            // Completion uses >= so a GOAL lowered below CURR stops instead of wrapping.
            if (count_en_c) begin
                if (curr_q >= goal_q) begin
                    state_q <= ST_COMPLETE;
                    start_q <= 1'b0;
                end else begin
                    curr_q <= curr_q + timerbits'(1);
                end
            end

            if (access_c) begin
                slverr_q <= ~in_range_c | (write & hit_curr_c);
                if (!in_range_c) begin
                    rdata_q <= '0;
                end else if (!write) begin
                    if (hit_status_c) begin
                        rdata_q <= status_c;
                        // Read-to-clear: caller sees COMPLETE, state drops to IDLE.
                        if (state_q == ST_COMPLETE) begin
                            state_q <= ST_IDLE;
                        end
                    end else if (hit_goal_c) begin
                        rdata_q <= goal_q;
                    end else begin
                        rdata_q <= curr_q;
                    end
                end else begin
                    if (hit_goal_c) begin
                        goal_q <= wdata;
                    end
                    if (hit_status_c) begin
                        if (!wdata[0]) begin
                            state_q <= ST_IDLE;
                            start_q <= 1'b0;
                            stop_q  <= 1'b0;
                        end else begin
                            // Fresh start clears CURR; a write while RUNNING only
                            // pauses or resumes. Starting with STOP set begins paused.
                            start_q <= 1'b1;
                            stop_q  <= wdata[1];
                            if (state_q != ST_RUNNING) begin
                                curr_q  <= '0;
                                state_q <= ST_RUNNING;
                            end
                        end
                    end
                end
            end
        end
    end

    assign rdata  = rdata_q;
    assign ready  = ready_q;
    assign slverr = slverr_q;

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed-vector bench for apb_timer.
module tb_apb_timer;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        enable;
    logic        write;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;
    logic        slverr;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] A_STATUS = 32'd0;
    localparam logic [31:0] A_GOAL   = 32'd1;
    localparam logic [31:0] A_CURR   = 32'd2;
    localparam logic [31:0] A_BAD    = 32'd3;

    apb_timer #(
        .timerbits    (8),
        .addrWidth    (32),
        .timerBaseAddr(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .enable(enable),
        .write (write),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .slverr(slverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One transfer: setup cycle, then access until ready (bounded).
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err);
        int n;
        n = 0;
        @(negedge clk);
        sel = 1'b1; enable = 1'b0; write = wr; addr = a; wdata = d;
        @(negedge clk);
        enable = 1'b1;
        while (!ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("xfer_ready", 32'(ready), 32'd1);
        rd = rdata;
        err = slverr;
        sel = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic wr_reg(input string tag, input logic [31:0] a, input logic [7:0] d,
                          input logic exp_err);
        logic [7:0] rd;
        logic       err;
        xfer(1'b1, a, d, rd, err);
        check(tag, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_reg(input string tag, input logic [31:0] a, input logic [7:0] exp,
                          input logic exp_err);
        logic [7:0] rd;
        logic       err;
        xfer(1'b0, a, 8'h00, rd, err);
        check({tag, "_data"}, 32'(rd), 32'(exp));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_val(input logic [31:0] a, output logic [7:0] v);
        logic err;
        xfer(1'b0, a, 8'h00, v, err);
    endtask

    initial begin
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;

        reset = 1'b1; sel = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_slverr", 32'(slverr), 32'h0);
        reset = 1'b0;

        // sel=0 with enable=1 must be ignored
        @(negedge clk);
        sel = 1'b0; enable = 1'b1; write = 1'b1; addr = A_STATUS; wdata = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nosel_ready", 32'(ready), 32'h0);
            check("nosel_rdata", 32'(rdata), 32'h0);
        end
        enable = 1'b0; write = 1'b0;
        rd_reg("nosel_status", A_STATUS, 8'h00, 1'b0);

        // Out-of-range and read-only errors
        wr_reg("goal_wr55", A_GOAL, 8'h55, 1'b0);
        rd_reg("bad_rd", A_BAD, 8'h00, 1'b1);
        wr_reg("bad_wr", A_BAD, 8'hAA, 1'b1);
        rd_reg("goal_kept", A_GOAL, 8'h55, 1'b0);
        wr_reg("curr_wr", A_CURR, 8'h77, 1'b1);
        rd_reg("curr_kept", A_CURR, 8'h00, 1'b0);
        rd_reg("status_kept", A_STATUS, 8'h00, 1'b0);

        // Count to 25 and read-to-clear
        wr_reg("goal_wr25", A_GOAL, 8'd25, 1'b0);
        wr_reg("start", A_STATUS, 8'h01, 1'b0);
        rd_val(A_CURR, c1);
        check("run_curr_nz", 32'(c1 != 8'h00), 32'd1);
        rd_reg("run_status", A_STATUS, 8'h05, 1'b0);
        repeat (30) @(negedge clk);
        rd_reg("done_status", A_STATUS, 8'h08, 1'b0);
        rd_reg("clr_status", A_STATUS, 8'h00, 1'b0);
        rd_reg("done_curr", A_CURR, 8'd25, 1'b0);

        // Pause, hold, resume
        wr_reg("start2", A_STATUS, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        wr_reg("pause", A_STATUS, 8'h03, 1'b0);
        rd_val(A_CURR, c1);
        repeat (4) @(negedge clk);
        rd_val(A_CURR, c2);
        check("pause_hold", 32'(c2), 32'(c1));
        check("pause_nz", 32'(c1 != 8'h00 && c1 < 8'd25), 32'd1);
        rd_reg("pause_status", A_STATUS, 8'h07, 1'b0);
        wr_reg("resume", A_STATUS, 8'h01, 1'b0);
        rd_val(A_CURR, c3);
        check("resume_from_held", 32'(c3 > c1 && c3 <= c1 + 8'd4), 32'd1);
        repeat (30) @(negedge clk);
        rd_reg("resume_done", A_STATUS, 8'h08, 1'b0);
        rd_reg("resume_curr", A_CURR, 8'd25, 1'b0);

        // Abort holds CURR
        wr_reg("start3", A_STATUS, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        wr_reg("abort", A_STATUS, 8'h00, 1'b0);
        rd_val(A_CURR, c1);
        repeat (3) @(negedge clk);
        rd_reg("abort_status", A_STATUS, 8'h00, 1'b0);
        rd_reg("abort_curr", A_CURR, c1, 1'b0);
        check("abort_curr_nz", 32'(c1 != 8'h00), 32'd1);

        // GOAL=0 completes right after start
        wr_reg("goal_wr0", A_GOAL, 8'h00, 1'b0);
        wr_reg("start0", A_STATUS, 8'h01, 1'b0);
        rd_reg("g0_status", A_STATUS, 8'h08, 1'b0);
        rd_reg("g0_curr", A_CURR, 8'h00, 1'b0);

        // Reset mid-count
        wr_reg("goal_wr25b", A_GOAL, 8'd25, 1'b0);
        wr_reg("start4", A_STATUS, 8'h01, 1'b0);
        rd_reg("pre_rst_status", A_STATUS, 8'h05, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_rdata", 32'(rdata), 32'h0);
        check("midrst_ready", 32'(ready), 32'h0);
        check("midrst_slverr", 32'(slverr), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd_reg("post_rst_status", A_STATUS, 8'h00, 1'b0);
        rd_reg("post_rst_goal", A_GOAL, 8'h00, 1'b0);
        rd_reg("post_rst_curr", A_CURR, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
